// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO map, STATUS layout,
// access-size decode and the big-endian lane helpers used by load and store paths.
package dmem_pkg;

  localparam logic [15:0] MMIO_BASE   = 16'hFFFF;
  localparam logic [15:0] REG_CONSOLE = 16'h0000;
  localparam logic [15:0] REG_STATUS  = 16'h0004;
  localparam logic [15:0] REG_CYCLES  = 16'h0008;
  localparam logic [15:0] REG_HALT    = 16'h000C;

  // STATUS bit positions in big-endian numbering (bit 0 = MSB)
  localparam int unsigned STATUS_HALTED_BIT   = 22;
  localparam int unsigned STATUS_MISALIGN_BIT = 23;
  localparam int unsigned STATUS_OVERFLOW_BIT = 24;
  localparam int unsigned STATUS_OCC_FIRST    = 25;
  localparam int unsigned STATUS_OCC_WIDTH    = 7;

  typedef enum logic [1:0] {
    SIZE_WORD,
    SIZE_HALF,
    SIZE_BYTE
  } access_size_e;

  function automatic access_size_e decode_size(input logic byte_sel, input logic half_sel);
    if (byte_sel)
      return SIZE_BYTE;
    else if (half_sel)
      return SIZE_HALF;
    return SIZE_WORD;
  endfunction

  function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] lane);
    unique case (sz)
      SIZE_WORD: return lane != 2'd0;
      SIZE_HALF: return lane[0];
      default:   return 1'b0;
    endcase
  endfunction

  // Lane k sits at value bits [31-8k -: 8], so the byte offset is 8*(3-k) = {~k, 3'b000}.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input access_size_e sz,
                                               input logic [1:0] lane, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{~lane, 3'b000} +: 8];
    h = word[{~lane[1], 4'b0000} +: 16];
    unique case (sz)
      SIZE_BYTE: return {{24{sext & b[7]}}, b};
      SIZE_HALF: return {{16{sext & h[15]}}, h};
      default:   return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input access_size_e sz,
                                              input logic [1:0] lane, input logic [31:0] data);
    logic [31:0] w;
    w = old;
    unique case (sz)
      SIZE_BYTE: w[{~lane, 3'b000} +: 8] = data[7:0];
      SIZE_HALF: w[{~lane[1], 4'b0000} +: 16] = data[15:0];
      default:   w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO for console bytes; a push while full is accepted only when a
// pop happens in the same cycle. Head reads as zero when empty.
module console_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : storage[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Big-endian data memory with zero-latency loads plus a small MMIO block:
// console byte FIFO, STATUS, free-running CYCLES counter and a sticky HALT flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  input  logic [0:31] data_to_mem,
  output logic [0:31] data_from_mem,
  output logic        tx_valid,
  output logic [0:7]  tx_data,
  input  logic        tx_ready,
  output logic        misalign_err,
  output logic        overflow_err,
  output logic        halted
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Internal datapath uses value-ordered [31:0] vectors; the numeric value is
  // identical to the big-endian port, so bit 31-i here is port bit i.
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [1:0]    lane;
  access_size_e  size;
  logic          misaligned;
  logic          is_mmio;
  logic [15:0]   offset;
  logic          store_ok;
  logic          ram_we;
  logic          console_push;
  logic          cycles_clear;
  logic          halt_store;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;

  logic [31:0]   cycle_count;
  logic [0:31]   status_be;
  logic [31:0]   mmio_word;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;

  assign addr       = addr_to_mem;
  assign wdata      = data_to_mem;
  assign lane       = addr[1:0];
  assign size       = decode_size(byte_to_mem, half_word_to_mem);
  assign misaligned = is_misaligned(size, lane);
  assign is_mmio    = (addr[31:16] == MMIO_BASE);
  assign offset     = addr[15:0];

  assign store_ok     = write_enable_to_mem && !misaligned;
  assign ram_we       = store_ok && !is_mmio;
  assign console_push = store_ok && is_mmio && (offset == REG_CONSOLE);
  assign cycles_clear = store_ok && is_mmio && (offset == REG_CYCLES);
  assign halt_store   = store_ok && is_mmio && (offset == REG_HALT);

  assign word_idx = addr[AW+1:2];
  assign ram_word = ram[word_idx];

  always_ff @(posedge clock) begin
    if (ram_we)
      ram[word_idx] <= merge_store(ram_word, size, lane, wdata);
  end

  always_comb begin
    status_be                                        = '0;
    status_be[STATUS_HALTED_BIT]                     = halted;
    status_be[STATUS_MISALIGN_BIT]                   = misalign_err;
    status_be[STATUS_OVERFLOW_BIT]                   = overflow_err;
    status_be[STATUS_OCC_FIRST +: STATUS_OCC_WIDTH]  = STATUS_OCC_WIDTH'(fifo_count);
  end

  always_comb begin
    mmio_word = '0;
    unique case (offset)
      REG_STATUS: mmio_word = status_be;
      REG_CYCLES: mmio_word = cycle_count;
      default:    mmio_word = '0;
    endcase
  end

  // MMIO registers are treated as ordinary words, so sub-word loads pick lanes the same way.
  always_comb begin
    rdata = '0;
    if (!misaligned)
      rdata = load_extract(is_mmio ? mmio_word : ram_word, size, lane, sign_extend_to_mem);
  end

  assign data_from_mem = rdata;

  assign fifo_pop = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_console_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (console_push),
    .push_data (wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count  <= '0;
      misalign_err <= 1'b0;
      overflow_err <= 1'b0;
      halted       <= 1'b0;
    end else begin
      cycle_count <= cycles_clear ? '0 : cycle_count + 32'd1;
      if (misaligned)
        misalign_err <= 1'b1;
      if (console_push && fifo_full && !fifo_pop)
        overflow_err <= 1'b1;
      if (halt_store)
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of load/store vectors with hand-computed
// results, plus sequences for CYCLES, console FIFO, halt and mid-transfer reset.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic [0:31] addr_to_mem;
  logic        write_enable_to_mem;
  logic        byte_to_mem;
  logic        half_word_to_mem;
  logic        sign_extend_to_mem;
  logic [0:31] data_to_mem;
  logic [0:31] data_from_mem;
  logic        tx_valid;
  logic [0:7]  tx_data;
  logic        tx_ready;
  logic        misalign_err;
  logic        overflow_err;
  logic        halted;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        we;
    logic        b;
    logic        h;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(
    .DEPTH_WORDS (4096),
    .FIFO_DEPTH  (8)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .addr_to_mem         (addr_to_mem),
    .write_enable_to_mem (write_enable_to_mem),
    .byte_to_mem         (byte_to_mem),
    .half_word_to_mem    (half_word_to_mem),
    .sign_extend_to_mem  (sign_extend_to_mem),
    .data_to_mem         (data_to_mem),
    .data_from_mem       (data_from_mem),
    .tx_valid            (tx_valid),
    .tx_data             (tx_data),
    .tx_ready            (tx_ready),
    .misalign_err        (misalign_err),
    .overflow_err        (overflow_err),
    .halted              (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic b, input logic h, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    write_enable_to_mem = we;
    byte_to_mem         = b;
    half_word_to_mem    = h;
    sign_extend_to_mem  = sx;
    addr_to_mem         = a;
    data_to_mem         = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b0, 1'b0, 1'b0, a, 32'h0);
    @(negedge clock);
    chk(name, data_from_mem, exp);
    tick();
  endtask

  task automatic console_byte(input logic [7:0] v);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_0000, {24'h0, v});
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    tx_ready = 1'b0;
    idle();
    reset = 1'b1;

    //            we b  h  sx addr          data          chk exp
    vecs.push_back('{1, 0, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0});
    vecs.push_back('{0, 1, 0, 1, 32'h0000_0100, 32'h0,         1, 32'hFFFF_FFDE});
    vecs.push_back('{0, 1, 0, 1, 32'h0000_0101, 32'h0,         1, 32'hFFFF_FFAD});
    vecs.push_back('{0, 1, 0, 1, 32'h0000_0102, 32'h0,         1, 32'hFFFF_FFBE});
    vecs.push_back('{0, 1, 0, 1, 32'h0000_0103, 32'h0,         1, 32'hFFFF_FFEF});
    vecs.push_back('{0, 0, 1, 0, 32'h0000_0102, 32'h0,         1, 32'h0000_BEEF});
    vecs.push_back('{0, 0, 1, 1, 32'h0000_0100, 32'h0,         1, 32'hFFFF_DEAD});
    vecs.push_back('{0, 1, 0, 0, 32'h0000_0103, 32'h0,         1, 32'h0000_00EF});
    vecs.push_back('{0, 0, 0, 1, 32'h0000_0100, 32'h0,         1, 32'hDEAD_BEEF});
    vecs.push_back('{1, 0, 0, 0, 32'h0000_0200, 32'h1122_3344, 0, 32'h0});
    vecs.push_back('{1, 1, 0, 0, 32'h0000_0201, 32'hAAAA_AA55, 0, 32'h0});
    vecs.push_back('{0, 0, 0, 0, 32'h0000_0200, 32'h0,         1, 32'h1155_3344});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0202, 32'hFFFF_7E01, 0, 32'h0});
    vecs.push_back('{0, 0, 0, 0, 32'h0000_0200, 32'h0,         1, 32'h1155_7E01});
    vecs.push_back('{0, 0, 1, 1, 32'h0000_0202, 32'h0,         1, 32'h0000_7E01});
    vecs.push_back('{0, 0, 1, 1, 32'h0000_0200, 32'h0,         1, 32'h0000_1155});
    vecs.push_back('{1, 0, 0, 0, 32'h0000_0300, 32'hCAFE_F00D, 0, 32'h0});
    vecs.push_back('{0, 0, 0, 0, 32'h0000_4300, 32'h0,         1, 32'hCAFE_F00D});
    vecs.push_back('{0, 1, 1, 0, 32'h0000_0301, 32'h0,         1, 32'h0000_00FE});
    vecs.push_back('{0, 1, 1, 1, 32'h0000_0302, 32'h0,         1, 32'hFFFF_FFF0});
    vecs.push_back('{0, 0, 0, 0, 32'hFFFF_0004, 32'h0,         1, 32'h0000_0000});
    vecs.push_back('{0, 0, 0, 0, 32'hFFFF_0000, 32'h0,         1, 32'h0000_0000});
    vecs.push_back('{0, 0, 0, 0, 32'hFFFF_0010, 32'h0,         1, 32'h0000_0000});
    vecs.push_back('{1, 0, 0, 0, 32'h0000_0102, 32'h1234_5678, 1, 32'h0000_0000});
    vecs.push_back('{0, 0, 0, 0, 32'h0000_0100, 32'h0,         1, 32'hDEAD_BEEF});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0201, 32'h0000_FFFF, 1, 32'h0000_0000});
    vecs.push_back('{0, 0, 0, 0, 32'h0000_0200, 32'h0,         1, 32'h1155_7E01});
    vecs.push_back('{0, 0, 0, 0, 32'hFFFF_0004, 32'h0,         1, 32'h0000_0100});
    vecs.push_back('{0, 0, 0, 0, 32'hFFFF_0006, 32'h0,         1, 32'h0000_0000});

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
    chk("reset_flags", {29'h0, halted, misalign_err, overflow_err}, 32'h0);

    // CYCLES: ten edges after reset release reads 10; a store clears it
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    load_word_check("cycles_after_10", 32'hFFFF_0008, 32'd10);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_0008, 32'h1234_5678);
    tick();
    load_word_check("cycles_cleared", 32'hFFFF_0008, 32'd0);
    load_word_check("cycles_next", 32'hFFFF_0008, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].b, vecs[i].h, vecs[i].sx, vecs[i].addr, vecs[i].data);
      @(negedge clock);
      if (vecs[i].chk)
        chk($sformatf("vec%0d_@%08h", i, vecs[i].addr), data_from_mem, vecs[i].exp);
      tick();
    end
    idle();
    chk("misalign_err_set", {31'h0, misalign_err}, 32'h1);

    // Console overflow: nine pushes into an 8-entry FIFO with the sink stalled
    for (int i = 0; i < 9; i++)
      console_byte(8'h41 + 8'(i));
    idle();
    chk("overflow_err", {31'h0, overflow_err}, 32'h1);
    chk("tx_valid_full", {31'h0, tx_valid}, 32'h1);
    load_word_check("status_full", 32'hFFFF_0004, 32'h0000_0188);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("drain%0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h41 + 8'(i)});
      tick();
    end
    @(negedge clock);
    chk("drained_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    tick();

    // HALT is sticky; RAM and console still accept stores
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_000C, 32'h0);
    tick();
    idle();
    chk("halted_set", {31'h0, halted}, 32'h1);
    repeat (3) tick();
    chk("halted_sticky", {31'h0, halted}, 32'h1);
    load_word_check("status_halted", 32'hFFFF_0004, 32'h0000_0380);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0BAD_F00D);
    tick();
    load_word_check("ram_after_halt", 32'h0000_0400, 32'h0BAD_F00D);
    console_byte(8'h5A);
    idle();
    chk("console_after_halt", {23'h0, tx_valid, tx_data}, 32'h0000_015A);
    console_byte(8'h5B);
    console_byte(8'h5C);
    idle();

    // Reset with bytes queued discards them and clears flags; RAM survives
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_tx", {23'h0, tx_valid, tx_data}, 32'h0);
    chk("midreset_flags", {29'h0, halted, misalign_err, overflow_err}, 32'h0);
    load_word_check("ram_survives_reset", 32'h0000_0100, 32'hDEAD_BEEF);
    load_word_check("status_after_reset", 32'hFFFF_0004, 32'h0);

    // Push into a full FIFO in the same cycle as a pop is accepted
    for (int i = 0; i < 8; i++)
      console_byte(8'h60 + 8'(i));
    tx_ready = 1'b1;
    console_byte(8'h68);
    tx_ready = 1'b0;
    idle();
    chk("push_pop_no_overflow", {31'h0, overflow_err}, 32'h0);
    load_word_check("status_push_pop", 32'hFFFF_0004, 32'h0000_0008);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("drain_pp%0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h61 + 8'(i)});
      tick();
    end
    @(negedge clock);
    chk("drained_pp_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, meaning RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning console FIFO entries (power of two).
REQ-003 SHALL have port clock, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port addr_to_mem, input, [0:31]: byte address from the processor MEM stage.
REQ-006 SHALL have port write_enable_to_mem, input, 1: store request.
REQ-007 SHALL have ports byte_to_mem and half_word_to_mem, input, 1 each: access size; both low means word; both high is treated as byte.
REQ-008 SHALL have port sign_extend_to_mem, input, 1: sign-extend sub-word loads.
REQ-009 SHALL have port data_to_mem, input, [0:31]: store data, right-justified for sub-word stores.
REQ-010 SHALL have port data_from_mem, output, [0:31]: load data, right-justified.
REQ-011 SHALL have ports tx_valid (output, 1), tx_data (output, [0:7]) and tx_ready (input, 1): console byte stream.
REQ-012 SHALL have ports misalign_err, overflow_err and halted, output, 1 each: sticky flags.

Function
REQ-013 SHALL use big-endian bit and byte order: bit 0 is the MSB; byte lane k = addr[30:31] occupies bits [8k:8k+7].
REQ-014 SHALL decode MMIO when addr[0:15]==16'hFFFF; all other addresses SHALL map to RAM at word index addr[30-log2(DEPTH_WORDS):29], wrapping modulo DEPTH_WORDS.
REQ-015 SHALL produce data_from_mem combinationally from the current inputs and registered state (zero-cycle load latency).
REQ-016 SHALL commit stores at the rising edge of the cycle in which write_enable_to_mem is high; a load in the following cycle SHALL return the new data.
REQ-017 SHALL, for byte stores, write data_to_mem[24:31] to lane addr[30:31] only; for halfword stores, write data_to_mem[16:31] to lanes 2*addr[30] and 2*addr[30]+1 only.
REQ-018 SHALL, for byte and halfword loads, place the selected lane(s) in the low bits and fill the upper bits with zeros or copies of the selected MSB according to sign_extend_to_mem; sign extension SHALL have no effect on word loads.
REQ-019 SHALL treat a halfword access with addr[31]=1 or a word access with addr[30:31]!=0 as misaligned: store suppressed, load returns 0, misalign_err set.
REQ-020 SHALL implement these MMIO registers at addr[16:31]: 0x0000 CONSOLE, 0x0004 STATUS, 0x0008 CYCLES, 0x000C HALT; other offsets SHALL read 0 and ignore stores.
REQ-021 SHALL, on a store to CONSOLE of any size, push data_to_mem[24:31] into the console FIFO; a load from CONSOLE SHALL return 0.
REQ-022 SHALL, on a CONSOLE push while the FIFO is full and not popping in the same cycle, drop the byte and set overflow_err; if a pop occurs in the same cycle, it SHALL accept the push.
REQ-023 SHALL drive tx_valid high while the FIFO is non-empty, with tx_data equal to the head entry; it SHALL pop on tx_valid && tx_ready.
REQ-024 SHALL make a STATUS load return {22'b0, halted, misalign_err, overflow_err, occupancy[7 bits]} (bits [0:21], 22, 23, 24, [25:31]); STATUS SHALL be read-only.
REQ-025 SHALL make CYCLES a 32-bit free-running counter that increments every cycle and wraps from 0xFFFFFFFF to 0; stores to CYCLES SHALL clear it to 0 at that edge.
REQ-026 SHALL set halted on any store to HALT; halted SHALL be sticky; RAM and console stores SHALL remain enabled after halt.
REQ-027 SHALL apply the misalignment rule of REQ-019 to MMIO accesses as well.

Reset
REQ-028 SHALL, on reset, clear the FIFO (tx_valid=0, tx_data=0), set CYCLES=0, and clear misalign_err, overflow_err and halted.
REQ-029 SHALL leave RAM contents unaffected by reset; reset asserted mid-transfer SHALL discard queued console bytes.

Structure
REQ-030 SHALL take the MMIO base, register offsets and STATUS bit positions from shared package dmem_pkg.
REQ-031 SHALL instantiate one sub-module, console_fifo (synchronous FIFO with push, pop, full, empty and count).

Verification
REQ-032 SHALL pass: word store 0xDEADBEEF to 0x100, then byte loads at 0x100..0x103 with sign extension -> 0xFFFFFFDE, 0xFFFFFFAD, 0xFFFFFFBE, 0xFFFFFFEF; halfword load at 0x102 without sign extension -> 0x0000BEEF.
REQ-033 SHALL pass: byte store 0x55 to 0x101 over 0x11223344 -> word load returns 0x11553344.
REQ-034 SHALL pass: word store to 0x102 -> memory unchanged, load 0, misalign_err=1, STATUS bit 23=1.
REQ-035 SHALL pass: with tx_ready=0, push 9 bytes 0x41..0x49 -> occupancy=8, overflow_err=1; then with tx_ready=1 -> tx_data pops 0x41..0x48 on consecutive cycles.
REQ-036 SHALL pass: run 10 cycles after reset and load CYCLES -> 10; store to HALT -> halted=1 until the next reset.
